// File: rtl/game_event_handler_if.sv
// Collision/frame inputs and game-state outputs of the event handler.
// master = game controller side, slave = the event handler.
interface game_event_handler_if;
    logic        startOfFrame;
    logic        startGame;
    logic        coinCollision;
    logic        ghostCollision;
    logic        wallHitPulse;
    logic [2:0]  gameState;
    logic [1:0]  lives;
    logic [7:0]  coinsLeft;
    logic [15:0] score;
    logic        coinEatPulse;
    logic        deathPulse;
    logic [7:0]  wallBumpCount;
    logic        pacmanFreeze;

    modport master (
        output startOfFrame, startGame, coinCollision, ghostCollision, wallHitPulse,
        input  gameState, lives, coinsLeft, score, coinEatPulse, deathPulse,
               wallBumpCount, pacmanFreeze
    );

    modport slave (
        input  startOfFrame, startGame, coinCollision, ghostCollision, wallHitPulse,
        output gameState, lives, coinsLeft, score, coinEatPulse, deathPulse,
               wallBumpCount, pacmanFreeze
    );
endinterface

// File: rtl/game_event_handler.sv
// Game event handler: folds per-pixel collision levels into at most one
// committed event per frame and keeps the game-level state (FSM, lives,
// coins, BCD score, wall bump count). Every output comes from a flop.
module game_event_handler #(
    parameter int unsigned INIT_LIVES      = 3,
    parameter int unsigned TOTAL_COINS     = 64,
    parameter logic [15:0] COIN_POINTS_BCD = 16'h0010,
    parameter int unsigned DEATH_FRAMES    = 60
) (
    input logic                 clk,
    input logic                 resetN,
    game_event_handler_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_DEATH = 3'd2,
        S_WIN   = 3'd3,
        S_OVER  = 3'd4
    } state_e;

    state_e      state_q;
    logic [1:0]  lives_q;
    logic [7:0]  coins_q;
    logic [15:0] score_q;
    logic [15:0] score_d;
    logic        coin_pulse_q;
    logic        death_pulse_q;
    logic [7:0]  wall_q;
    logic        freeze_q;
    logic        coin_seen_q;
    logic        ghost_seen_q;
    logic [7:0]  frame_cnt_q;

    // Packed BCD add with per-digit carry; a carry out of the top digit
    // pins the score at 9999 instead of wrapping.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [4:0]  d;
        logic        c;
        r = 16'h0000;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
            if (d > 5'd9) begin
                d = d + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = d[3:0];
        end
        return c ? 16'h9999 : r;
    endfunction

    // Score value a coin commit would load.
    always_comb begin
        score_d = bcd_add_sat(score_q, COIN_POINTS_BCD);
    end

    // Game FSM, frame latches, counters and registered pulses.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= S_IDLE;
            lives_q       <= 2'd0;
            coins_q       <= 8'd0;
            score_q       <= 16'h0000;
            coin_pulse_q  <= 1'b0;
            death_pulse_q <= 1'b0;
            wall_q        <= 8'd0;
            freeze_q      <= 1'b1;
            coin_seen_q   <= 1'b0;
            ghost_seen_q  <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            coin_pulse_q  <= 1'b0;
            death_pulse_q <= 1'b0;
            case (state_q)
                S_IDLE, S_WIN, S_OVER: begin
                    coin_seen_q  <= 1'b0;
                    ghost_seen_q <= 1'b0;
                    if (bus.startGame) begin
                        state_q  <= S_PLAY;
                        freeze_q <= 1'b0;
                        lives_q  <= INIT_LIVES[1:0];
                        coins_q  <= TOTAL_COINS[7:0];
                        score_q  <= 16'h0000;
                        wall_q   <= 8'd0;
                    end
                end
                S_PLAY: begin
                    if (bus.wallHitPulse) wall_q <= wall_q + 8'd1;
                    if (bus.startOfFrame) begin
                        // Commit last frame; a collision on this cycle seeds the new frame.
                        coin_seen_q  <= bus.coinCollision;
                        ghost_seen_q <= bus.ghostCollision;
                        if (ghost_seen_q) begin
                            // Ghost wins: any coin seen in the same frame is dropped.
                            lives_q       <= lives_q - 2'd1;
                            death_pulse_q <= 1'b1;
                            frame_cnt_q   <= DEATH_FRAMES[7:0];
                            state_q       <= S_DEATH;
                            freeze_q      <= 1'b1;
                            wall_q        <= 8'd0;
                            coin_seen_q   <= 1'b0;
                            ghost_seen_q  <= 1'b0;
                        end else if (coin_seen_q && coins_q != 8'd0) begin
                            coins_q      <= coins_q - 8'd1;
                            coin_pulse_q <= 1'b1;
                            score_q      <= score_d;
                            if (coins_q == 8'd1) begin
                                state_q      <= S_WIN;
                                freeze_q     <= 1'b1;
                                coin_seen_q  <= 1'b0;
                                ghost_seen_q <= 1'b0;
                            end
                        end
                    end else begin
                        coin_seen_q  <= coin_seen_q  | bus.coinCollision;
                        ghost_seen_q <= ghost_seen_q | bus.ghostCollision;
                    end
                end
                S_DEATH: begin
                    coin_seen_q  <= 1'b0;
                    ghost_seen_q <= 1'b0;
                    if (bus.startOfFrame) begin
                        // Leave on the frame that exhausts the counter, so DEATH
                        // lasts exactly DEATH_FRAMES frames.
                        if (frame_cnt_q <= 8'd1) begin
                            frame_cnt_q <= 8'd0;
                            if (lives_q == 2'd0) begin
                                state_q  <= S_OVER;
                                freeze_q <= 1'b1;
                            end else begin
                                state_q  <= S_PLAY;
                                freeze_q <= 1'b0;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    freeze_q     <= 1'b1;
                    coin_seen_q  <= 1'b0;
                    ghost_seen_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gameState     = state_q;
    assign bus.lives         = lives_q;
    assign bus.coinsLeft     = coins_q;
    assign bus.score         = score_q;
    assign bus.coinEatPulse  = coin_pulse_q;
    assign bus.deathPulse    = death_pulse_q;
    assign bus.wallBumpCount = wall_q;
    assign bus.pacmanFreeze  = freeze_q;

endmodule
